// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants and FSM state type for the load/store data-memory controller
package lsu_pkg;

    localparam int LSU_ADDR_W = 32;
    localparam int LSU_DATA_W = 32;
    localparam int LSU_IMM_W  = 16;
    localparam int LSU_DEPTH  = 1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_agen.sv
// rtl/lsu_agen.sv - effective address generator: base + sign-extended offset, with range flag
import lsu_pkg::*;

module lsu_agen #(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int IMM_W  = LSU_IMM_W,
    parameter int DEPTH  = LSU_DEPTH
) (
    input  logic [ADDR_W-1:0] i_base,
    input  logic [IMM_W-1:0]  i_imm,
    output logic [ADDR_W-1:0] o_ea,
    output logic              o_out_of_range
);

    logic [ADDR_W-1:0] w_imm_sext;

    // Sign-extend the offset; the add wraps silently modulo 2^ADDR_W.
    always_comb begin
        w_imm_sext     = {{(ADDR_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};
        o_ea           = i_base + w_imm_sext;
        o_out_of_range = (o_ea >= ADDR_W'(DEPTH));
    end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// rtl/lsu_dmem_ctrl.sv - LSU data-memory initiator (IDLE/ACCESS/RESP); LSU_BOUNDS_CHECK_EN enables EA range fault
import lsu_pkg::*;

module lsu_dmem_ctrl #(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DATA_W = LSU_DATA_W,
    parameter int IMM_W  = LSU_IMM_W,
    parameter int DEPTH  = LSU_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [IMM_W-1:0]  req_imm,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    lsu_state_e        r_state;
    lsu_state_e        w_state_nxt;

    logic [ADDR_W-1:0] r_ea;
    logic              r_is_store;
    logic [DATA_W-1:0] r_wdata;
    logic              r_oor;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic [ADDR_W-1:0] w_ea;
    logic              w_oor;
    logic              w_accept;
    logic              w_block;

    lsu_agen #(
        .ADDR_W (ADDR_W),
        .IMM_W  (IMM_W),
        .DEPTH  (DEPTH)
    ) u_agen (
        .i_base         (req_base),
        .i_imm          (req_imm),
        .o_ea           (w_ea),
        .o_out_of_range (w_oor)
    );

    assign w_accept = (r_state == ST_IDLE) && req_valid;

`ifdef LSU_BOUNDS_CHECK_EN
    // An out-of-range request still spends its ACCESS cycle but never strobes memory.
    assign w_block = r_oor;
`else
    // No checking: upper EA bits simply alias inside the memory.
    logic w_unused_oor;
    assign w_unused_oor = r_oor;
    assign w_block      = 1'b0;
`endif

    // State register; reset drops any in-flight request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state: one ACCESS cycle per request, RESP waits for the consumer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (req_valid) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   if (rsp_ready) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch the request at acceptance; memory address/data hold these values until the next accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ea       <= '0;
            r_is_store <= 1'b0;
            r_wdata    <= '0;
            r_oor      <= 1'b0;
        end else if (w_accept) begin
            r_ea       <= w_ea;
            r_is_store <= req_is_store;
            r_wdata    <= req_wdata;
            r_oor      <= w_oor;
        end
    end

    // Capture the response at the closing edge of ACCESS; stores and faults return zero data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (r_state == ST_ACCESS) begin
            r_rdata <= (!r_is_store && !w_block) ? mem_dout : '0;
            r_err   <= w_block;
        end
    end

    // Outputs decoded from state; strobes exist only in ACCESS and are mutually exclusive.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        case (r_state)
            ST_IDLE:   req_ready = 1'b1;
            ST_ACCESS: begin
                mem_write = r_is_store  && !w_block;
                mem_read  = !r_is_store && !w_block;
            end
            ST_RESP:   rsp_valid = 1'b1;
            default:   req_ready = 1'b0;
        endcase
    end

    assign mem_addr  = r_ea;
    assign mem_din   = r_wdata;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
